// File: rtl/mod_add_sub_seq.sv
// Limb-serial modular adder/subtractor: (a + b) mod P or (a - b) mod P.
// A primary and a candidate (corrected) result are built one LIMB-bit slice per cycle.
module mod_add_sub_seq #(
  parameter int N    = 256,
  parameter int LIMB = 64,
  parameter logic [N-1:0] P = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         wrap
);

  localparam int L  = N / LIMB;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [N-1:0]    opA_q, opB_q, mod_q;
  logic [N-1:0]    prim_q, cand_q;
  logic [N-1:0]    result_q;
  logic            sub_q, primCarry_q, candCarry_q, wrap_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            lastLimb;
  logic [LIMB:0]   primW, candW;
  logic [N+LIMB-1:0] primCat, candCat;
  logic [N-1:0]    prim_d, cand_d;
  logic            chooseCand;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign wrap      = wrap_q;
  assign lastLimb  = (cnt_q == CW'(L - 1));

  // Top bit of each (LIMB+1)-bit limb sum/difference is the carry or borrow out.
  always_comb begin
    primW = '0;
    candW = '0;
    if (!sub_q) begin
      primW = {1'b0, opA_q[LIMB-1:0]} + {1'b0, opB_q[LIMB-1:0]} + {{LIMB{1'b0}}, primCarry_q};
      candW = {1'b0, primW[LIMB-1:0]} - {1'b0, mod_q[LIMB-1:0]} - {{LIMB{1'b0}}, candCarry_q};
    end else begin
      primW = {1'b0, opA_q[LIMB-1:0]} - {1'b0, opB_q[LIMB-1:0]} - {{LIMB{1'b0}}, primCarry_q};
      candW = {1'b0, primW[LIMB-1:0]} + {1'b0, mod_q[LIMB-1:0]} + {{LIMB{1'b0}}, candCarry_q};
    end
  end

  // New limbs enter at the top so that after L cycles limb 0 sits at bit 0.
  assign primCat = {primW[LIMB-1:0], prim_q};
  assign candCat = {candW[LIMB-1:0], cand_q};
  assign prim_d  = primCat[N+LIMB-1:LIMB];
  assign cand_d  = candCat[N+LIMB-1:LIMB];

  // Add: take s-P when s >= P over N+1 bits. Sub: take d+P when a-b borrowed.
  assign chooseCand = sub_q ? primW[LIMB] : (primW[LIMB] | ~candW[LIMB]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      mod_q       <= '0;
      prim_q      <= '0;
      cand_q      <= '0;
      result_q    <= '0;
      sub_q       <= 1'b0;
      primCarry_q <= 1'b0;
      candCarry_q <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        RUN: begin
          opA_q       <= opA_q >> LIMB;
          opB_q       <= opB_q >> LIMB;
          mod_q       <= mod_q >> LIMB;
          prim_q      <= prim_d;
          cand_q      <= cand_d;
          primCarry_q <= primW[LIMB];
          candCarry_q <= candW[LIMB];
          cnt_q       <= cnt_q + CW'(1);
          if (lastLimb) begin
            state_q  <= DONE;
            result_q <= chooseCand ? cand_d : prim_d;
            wrap_q   <= chooseCand;
          end
        end
        default: begin
          if (accept) begin
            state_q     <= RUN;
            opA_q       <= a;
            opB_q       <= b;
            mod_q       <= P;
            sub_q       <= op;
            prim_q      <= '0;
            cand_q      <= '0;
            primCarry_q <= 1'b0;
            candCarry_q <= 1'b0;
            cnt_q       <= '0;
          end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_add_sub_seq.sv
// Scoreboard bench for mod_add_sub_seq: expected results are queued at accept
// and compared whenever the DUT hands a result over.
module tb_mod_add_sub_seq;

  localparam int N  = 256;
  localparam int NW = N + 1;
  localparam int L  = 4;
  localparam logic [N-1:0] P = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  typedef struct packed {
    logic [N-1:0] res;
    logic         wr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [N-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         wrap;

  logic stallMode, randReady, readyForce;
  exp_t sbQ[$];
  exp_t monExp;
  int   checks   = 0;
  int   failures = 0;

  assign out_ready = stallMode ? randReady : readyForce;

  mod_add_sub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Consumer stalls roughly one cycle in four when random back-pressure is on.
  always @(posedge clk) randReady <= ($urandom_range(0, 3) != 0);

  task automatic checkOutput(input string tag, input logic [NW-1:0] observed, input logic [NW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic exp_t refModel(input logic opIn, input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s;
    exp_t e;
    if (!opIn) begin
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, P}) begin
        s    = s - {1'b0, P};
        e.wr = 1'b1;
      end else begin
        e.wr = 1'b0;
      end
      e.res = s[N-1:0];
    end else begin
      if (x >= y) begin
        e.res = x - y;
        e.wr  = 1'b0;
      end else begin
        e.res = x - y + P;
        e.wr  = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [N-1:0] randElem();
    logic [N-1:0] v;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return '0;
    if (sel == 1) return P - 1;
    do begin
      for (int w = 0; w < N / 32; w++) v[w*32 +: 32] = $urandom;
      v[N-1] = 1'b0;
    end while (v >= P);
    return v;
  endfunction

  // Result monitor: pops the oldest expectation on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_result", NW'(1), NW'(0));
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("result", NW'(result), NW'(monExp.res));
        checkOutput("wrap", NW'(wrap), NW'(monExp.wr));
      end
    end
  end

  task automatic applyStimulus(input logic o, input logic [N-1:0] x, input logic [N-1:0] y, output int waitCyc);
    bit done;
    done    = 0;
    waitCyc = 0;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      waitCyc++;
      if (in_ready) begin
        @(posedge clk);
        sbQ.push_back(refModel(o, x, y));
        done = 1;
      end
    end
    #1;
    in_valid = 1'b0;
    a        = ~x;
    b        = ~y;
    if (!done) checkOutput("accept_timeout", NW'(0), NW'(1));
  endtask

  task automatic waitValid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 100);
    if (!out_valid) checkOutput("valid_timeout", NW'(0), NW'(1));
  endtask

  logic         dOp[7];
  logic [N-1:0] dA[7], dB[7];
  int           cyc, waitCyc;
  bit           sawValid;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    op         = 1'b0;
    a          = '0;
    b          = '0;
    stallMode  = 1'b0;
    readyForce = 1'b1;

    dOp[0] = 1'b0; dA[0] = N'(5);                              dB[0] = N'(7);
    dOp[1] = 1'b0; dA[1] = {192'b0, 64'hffff_ffff_ffff_ffff}; dB[1] = N'(1);
    dOp[2] = 1'b0; dA[2] = P - 1;                              dB[2] = P - 1;
    dOp[3] = 1'b0; dA[3] = P - 1;                              dB[3] = N'(1);
    dOp[4] = 1'b1; dA[4] = N'(3);                              dB[4] = N'(5);
    dOp[5] = 1'b1; dA[5] = N'(5);                              dB[5] = N'(3);
    dOp[6] = 1'b1; dA[6] = N'(0);                              dB[6] = N'(0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", NW'(in_ready), NW'(1));
    checkOutput("rst_out_valid", NW'(out_valid), NW'(0));
    checkOutput("rst_result", NW'(result), NW'(0));
    checkOutput("rst_wrap", NW'(wrap), NW'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed operations with latency and single-cycle valid checks.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(dOp[i], dA[i], dB[i], waitCyc);
      waitValid(cyc);
      checkOutput("latency", NW'(cyc), NW'(L));
      @(posedge clk);
      #1;
      checkOutput("valid_drop", NW'(out_valid), NW'(0));
    end

    // Back-pressure: result must hold while the consumer stalls.
    readyForce = 1'b0;
    applyStimulus(1'b0, N'(5), N'(7), waitCyc);
    waitValid(cyc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("stall_valid", NW'(out_valid), NW'(1));
      checkOutput("stall_result", NW'(result), NW'(12));
      checkOutput("stall_wrap", NW'(wrap), NW'(0));
      checkOutput("stall_in_ready", NW'(in_ready), NW'(0));
    end
    @(posedge clk);
    #1 readyForce = 1'b1;
    applyStimulus(1'b0, N'(1), N'(1), waitCyc);
    checkOutput("b2b_accept_wait", NW'(waitCyc), NW'(1));
    waitValid(cyc);
    checkOutput("b2b_latency", NW'(cyc), NW'(L));
    @(posedge clk);
    #1;

    // Reset during the second RUN cycle aborts the transaction.
    applyStimulus(1'b1, N'(3), N'(5), waitCyc);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sbQ.delete();
    @(negedge clk);
    checkOutput("abort_out_valid", NW'(out_valid), NW'(0));
    checkOutput("abort_in_ready", NW'(in_ready), NW'(1));
    checkOutput("abort_result", NW'(result), NW'(0));
    checkOutput("abort_wrap", NW'(wrap), NW'(0));
    sawValid = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1;
    end
    checkOutput("abort_no_stale", NW'(sawValid), NW'(0));

    // Random regression with consumer stalls.
    @(posedge clk);
    #1 stallMode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), randElem(), randElem(), waitCyc);
    end
    stallMode = 1'b0;
    for (int k = 0; k < 200 && sbQ.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    checkOutput("drain", NW'(sbQ.size()), NW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_add_sub_seq.md
Name: mod_add_sub_seq

Overview:
- Limb-serial modular adder/subtractor. Computes (a + b) mod P or (a - b) mod P, with P = 2^255 - 19 by default.
- Sits directly downstream of the integer add/sub datapath. It consumes raw N-bit operands and produces fully reduced field elements for the curve arithmetic pipeline.
- Processes one LIMB-bit slice per cycle using a registered carry/borrow chain, which trades latency for a short critical path.
- Valid/ready handshake on both the input and output sides.

Parameters:
- N, 256, operand/result width in bits.
- LIMB, 64, bits processed per cycle; N % LIMB must be 0; L = N/LIMB limbs.
- P, 2^255-19 (N bits), modulus; must satisfy 2 <= P < 2^N.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- op  input  1  0 = add, 1 = subtract (same encoding as the add/sub ctrl input).
- a  input  N  first operand; caller guarantees a < P.
- b  input  N  second operand; caller guarantees b < P.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  N  reduced result, in [0, P).
- wrap  output  1  1 when the modular correction (-P for add, +P for sub) was applied.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, result = 0, wrap = 0, limb counter = 0, all carries/borrows = 0.
- Reset mid-operation: rst_n low at any edge aborts any RUN or DONE transaction. No result is emitted, and the next cycle shows the reset values.
- State machine, IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: register a, b, op; clear carries; counter = 0; go to RUN.
  - Operand changes after the accept edge are ignored.
- State machine, RUN (exactly L cycles), limb i = counter:
  - Add, primary: s_i = a_i + b_i + c_s.
  - Add, candidate: t_i = s_i - P_i - br_t.
  - Sub, primary: d_i = a_i - b_i - br_d.
  - Sub, candidate: u_i = d_i + P_i + c_u.
  - Primary and candidate limbs are stored in two N-bit shift/accumulate registers. Carry/borrow bits are registered between limbs.
  - counter increments each cycle. At counter = L-1, go to DONE and latch result/wrap.
- Selection at the final limb:
  - Add: choose t iff (final c_s == 1) or (final br_t == 0), i.e. s >= P over N+1 bits; wrap = chosen-t.
  - Sub: choose u iff final br_d == 1; the carry out of u is discarded; wrap = br_d.
- State machine, DONE:
  - out_valid = 1, with result and wrap held stable until out_valid && out_ready.
  - On handshake: go to IDLE, or directly back to RUN if in_valid is high the same cycle.
  - in_ready = out_ready while in DONE, so back-to-back accept is allowed.
- Latency: with an accept at edge E, out_valid rises after edge E+L (L = 4 by default). Throughput is one op per L+1 cycles.
- Out-of-range inputs (a or b >= P): exactly one conditional correction as defined above. The output is deterministic but not guaranteed reduced; no error flag.
- Simultaneous events:
  - Reset has priority over handshakes.
  - in_valid during RUN is ignored (in_ready = 0).
  - out_ready outside DONE has no effect.

Test Plan:
- add a=5, b=7 -> result=12, wrap=0; out_valid asserted exactly 4 cycles after the accept edge, held 1 cycle with out_ready=1. Repeat with a=2^64-1, b=1 -> result=2^64 (cross-limb carry).
- add a=P-1, b=P-1 -> result=P-2, wrap=1; add a=P-1, b=1 -> result=0, wrap=1.
- sub a=3, b=5 -> result=P-2, wrap=1; sub a=5, b=3 -> result=2, wrap=0; sub a=0, b=0 -> result=0, wrap=0.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> result/wrap stable and in_ready=0. Then out_ready=1 with in_valid=1 (add 1+1) -> both accepted on the same edge; next result=2 after 4 more cycles.
- Reset mid-RUN: deassert rst_n at the 2nd RUN cycle for 1 cycle -> next cycle out_valid=0, in_ready=1, result=0; no stale result appears later.
- Random regression: 10k ops, random op, a, b uniform in [0,P), random out_ready stalls -> result matches a (+/-) b mod P and wrap matches the reference model.
